// File: rtl/reg_hex_uart_tx.sv
// Captures a 16-bit word on request and sends it as four lowercase hex digits plus a line
// terminator over 8N1 UART. Define HEX_TX_CRLF_EN to send CR LF instead of LF alone.
module reg_hex_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] value,
    output logic        ready,
    output logic        tx
);

    // Handshake: a request is taken on a rising edge where start=1 and ready=1;
    // ready stays low for the whole frame and start is ignored meanwhile.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef HEX_TX_CRLF_EN
    localparam logic [2:0] LAST_CHAR = 3'd5;
`else
    localparam logic [2:0] LAST_CHAR = 3'd4;
`endif

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      idx_q, idx_d;
    logic [15:0]     hold_q, hold_d;
    logic            tx_q, tx_d;
    logic            baud_end;
    logic [7:0]      cur_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h57 + {4'h0, n};
    endfunction

    function automatic logic [7:0] char_at(input logic [2:0] idx, input logic [15:0] w);
        logic [7:0] c;
        case (idx)
            3'd0:    c = hex_ascii(w[15:12]);
            3'd1:    c = hex_ascii(w[11:8]);
            3'd2:    c = hex_ascii(w[7:4]);
            3'd3:    c = hex_ascii(w[3:0]);
`ifdef HEX_TX_CRLF_EN
            3'd4:    c = 8'h0D;
`endif
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    assign baud_end = (baud_q == BAUD_LAST);
    assign cur_char = char_at(idx_q, hold_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
        end
    end

    // tx is computed one cycle ahead so the line itself comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    hold_d  = value;
                    idx_d   = '0;
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = cur_char[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_char[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q == LAST_CHAR) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign ready = (state_q == IDLE);
    assign tx    = tx_q;

endmodule

// File: tb/tb_reg_hex_uart_tx.sv
// Directed bench for reg_hex_uart_tx: decodes the serial stream at mid-bit and compares
// against hand-computed ASCII bytes and frame timing.
module tb_reg_hex_uart_tx;

    localparam int CPB = 4;
`ifdef HEX_TX_CRLF_EN
    localparam int NCHAR = 6;
`else
    localparam int NCHAR = 5;
`endif
    localparam int FRAME = NCHAR * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] value;
    logic        ready;
    logic        tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    logic prev_ready = 1'b1;

    logic [7:0] rx_buf [0:5];
    bit         rx_ok;

    reg_hex_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .ready (ready),
        .tx    (tx)
    );

    // ---------------- clock / reset / timing monitor ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_ready <= ready;
        if (prev_ready === 1'b1 && ready === 1'b0) fall_cyc <= cyc;
        if (prev_ready === 1'b0 && ready === 1'b1) rise_cyc <= cyc;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver / receiver tasks ----------------
    task automatic rx_byte(output logic [7:0] b, output bit ok);
        int t;
        t  = 0;
        ok = 1'b1;
        b  = '0;
        while (tx !== 1'b0 && t < 20 * CPB) begin
            @(negedge clk);
            t++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic rx_frame();
        logic [7:0] b;
        bit ok;
        rx_ok = 1'b1;
        for (int i = 0; i < NCHAR; i++) begin
            rx_byte(b, ok);
            rx_buf[i] = b;
            if (!ok) rx_ok = 1'b0;
        end
    endtask

    task automatic wait_ready(output bit ok);
        int t;
        t = 0;
        while (ready !== 1'b1 && t < FRAME + 20 * CPB) begin
            @(negedge clk);
            t++;
        end
        ok = (ready === 1'b1);
    endtask

    task automatic send(input logic [15:0] v);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        value = 16'h5a5a;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit quiet;
        rst   = 1'b0;
        start = 1'b0;
        value = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
            checks++;
            if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        end
        rst = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL reset_idle: tx=%b ready=%b want 1/1", tx, ready); end
    endtask

    task automatic test_digits(input string name, input logic [15:0] v, input logic [31:0] digits);
        logic [7:0] exp_q[$];
        bit ok;
        exp_q = {};
        exp_q.push_back(digits[31:24]);
        exp_q.push_back(digits[23:16]);
        exp_q.push_back(digits[15:8]);
        exp_q.push_back(digits[7:0]);
`ifdef HEX_TX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
        send(v);
        rx_frame();
        checks++;
        if (!rx_ok) begin errors++; $display("FAIL %s_framing: got bad start/stop want clean 8N1", name); end
        for (int i = 0; i < NCHAR; i++) begin
            checks++;
            if (rx_buf[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h want %h", name, i, rx_buf[i], exp_q[i]);
            end
        end
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_ready: got 0 want 1 after frame", name); end
    endtask

    task automatic test_abcd();
        logic [7:0] exp_q[$];
        bit ok;
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
`ifdef HEX_TX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
        @(negedge clk);
        value = 16'habcd;
        start = 1'b1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL abcd_pre_tx: got %b want 1", tx); end
        @(negedge clk);
        start = 1'b0;
        value = 16'h0000;
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL abcd_start_bit: got %b want 0", tx); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL abcd_busy: got %b want 0", ready); end
        rx_frame();
        checks++;
        if (!rx_ok) begin errors++; $display("FAIL abcd_framing: got bad start/stop want clean 8N1"); end
        for (int i = 0; i < NCHAR; i++) begin
            checks++;
            if (rx_buf[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abcd_byte%0d: got %h want %h", i, rx_buf[i], exp_q[i]);
            end
        end
        wait_ready(ok);
        @(negedge clk);
        checks++;
        if (!ok || (rise_cyc - fall_cyc) != FRAME) begin
            errors++;
            $display("FAIL abcd_ready_low: got %0d cycles want %0d", rise_cyc - fall_cyc, FRAME);
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] exp_q[$];
        bit ok;
        bit quiet;
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
`ifdef HEX_TX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
        send(16'habcd);
        fork
            rx_frame();
            begin
                repeat (20) @(negedge clk);
                value = 16'h1234;
                start = 1'b1;
                checks++;
                if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", ready); end
                @(negedge clk);
                start = 1'b0;
            end
        join
        checks++;
        if (!rx_ok) begin errors++; $display("FAIL busy_framing: got bad start/stop want clean 8N1"); end
        for (int i = 0; i < NCHAR; i++) begin
            checks++;
            if (rx_buf[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL busy_byte%0d: got %h want %h", i, rx_buf[i], exp_q[i]);
            end
        end
        wait_ready(ok);
        quiet = ok;
        repeat (30 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL busy_no_second_frame: got activity want idle line"); end
    endtask

    task automatic test_reset_mid();
        send(16'h0000);
        // Frame cycle 89: char 2, data bit 1 of '0' (0x30), which is 0.
        repeat (89) @(negedge clk);
        checks++;
        if (tx !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: got tx=%b ready=%b want 0/0", tx, ready);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midrst_async_tx: got %b want 1", tx); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL midrst_release: got tx=%b ready=%b want 1/1", tx, ready);
        end
        test_digits("after_rst_00ff", 16'h00ff, {8'h30, 8'h30, 8'h66, 8'h66});
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        bit ok;
        int t;
        exp_q = '{8'h37, 8'h65, 8'h30, 8'h30};
`ifdef HEX_TX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
        @(negedge clk);
        value = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        value = 16'h7e00;
        t = 0;
        while (ready !== 1'b1 && t < FRAME + 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (ready !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: got ready=%b tx=%b want 1/1", ready, tx);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (tx !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: got tx=%b ready=%b want 0/0", tx, ready);
        end
        checks++;
        if ((rise_cyc - fall_cyc) != FRAME) begin
            errors++;
            $display("FAIL b2b_ready_low: got %0d cycles want %0d", rise_cyc - fall_cyc, FRAME);
        end
        rx_frame();
        checks++;
        if (!rx_ok) begin errors++; $display("FAIL b2b_framing: got bad start/stop want clean 8N1"); end
        for (int i = 0; i < NCHAR; i++) begin
            checks++;
            if (rx_buf[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h want %h", i, rx_buf[i], exp_q[i]);
            end
        end
        wait_ready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_ready: got 0 want 1 after frame"); end
    endtask

    initial begin
        test_reset();
        test_abcd();
        test_digits("v0009", 16'h0009, {8'h30, 8'h30, 8'h30, 8'h39});
        test_digits("vffff", 16'hffff, {8'h66, 8'h66, 8'h66, 8'h66});
        test_digits("v1234", 16'h1234, {8'h31, 8'h32, 8'h33, 8'h34});
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_hex_uart_tx.md
Name: reg_hex_uart_tx

Overview:
Reader and reporter for a 16-bit Hack register value. It captures a 16-bit word on request and transmits it over the Mojo serial link as four lowercase ASCII hex digits followed by a line terminator. UART format is 8N1. The block is the hardware counterpart of the "%4h" register display and connects a register's out bus to the board's serial TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2 or more.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request to send; sampled on rising clk
value  input  16  word to report; captured when start && ready
ready  output  1  1 = idle, a request will be accepted this cycle
tx  output  1  UART serial out, idle high, registered

Behaviour:
- Reset (rst=0, asynchronous): tx=1, ready=1, FSM=IDLE, all counters 0, captured word cleared.
- Reset applied mid-frame aborts the frame at once: tx returns to 1 without waiting for a clock edge, and the remaining characters are discarded.
- Accept: on a rising edge with start=1 and ready=1:
  - value is latched into a 16-bit holding register.
  - ready goes 0 and the FSM enters START.
  - tx goes 0 from that edge, so the start bit begins one cycle after the request.
- start while ready=0 is ignored; the holding register is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit counter runs 0..7, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If more characters remain, go to START with the character index incremented. Otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state change.
- Character sequence (index 0..4): nibble[15:12], nibble[11:8], nibble[7:4], nibble[3:0], then 0x0A.
- Nibble encoding: 0-9 map to 0x30-0x39; a-f map to 0x61-0x66 (lowercase). Leading zeros are always sent; the output is always 4 digits.
- No idle gap between characters: the next start bit follows the previous stop bit directly.
- Frame length is 5 chars x 10 bits x CLKS_PER_BIT cycles.
- ready returns to 1 on the edge that ends the last stop bit, so it is high in the cycle after the final stop-bit cycle.
- Back-to-back: if start=1 in that cycle, the next frame's start bit begins one cycle later. The minimum request-to-request spacing is therefore frame length + 1 cycle.
- value may change freely after acceptance; only the latched copy is transmitted.

Optional Feature:
Macro: HEX_TX_CRLF_EN
- Defined: the terminator is 0x0D followed by 0x0A. There are 6 characters per frame and the index runs 0..5.
- Frame length is 60 x CLKS_PER_BIT cycles.
- Not defined: the terminator is 0x0A only, with 5 characters per frame (50 x CLKS_PER_BIT cycles).
- Port list and all other timing are identical in both builds.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release. Required: tx=1 and ready=1 during reset and afterward; no activity on tx.
- Value 16'habcd, CLKS_PER_BIT=4: pulse start for 1 cycle. Required:
  - tx falls 1 cycle later.
  - Decoded bytes are 0x61, 0x62, 0x63, 0x64, 0x0A.
  - ready=0 for exactly 200 cycles, then 1.
- Value 16'h0009 -> bytes 0x30, 0x30, 0x30, 0x39, 0x0A. Repeat with 16'hffff -> 0x66 x4, then 0x0A.
- Busy-ignore: 20 cycles into the 16'habcd frame, pulse start with value=16'h1234. Required: the frame still decodes as "abcd\n", and no second frame follows.
- Reset mid-frame: assert rst=0 during the DATA state of character 2. Required:
  - tx=1 immediately, without a clock edge.
  - ready=1 after release.
  - A new start with 16'h00ff then decodes as 0x30, 0x30, 0x66, 0x66, 0x0A.
- With HEX_TX_CRLF_EN defined: 16'h1234 -> bytes 0x31, 0x32, 0x33, 0x34, 0x0D, 0x0A. ready is low for 240 cycles at CLKS_PER_BIT=4. Holding start=1 continuously makes the second frame's start bit begin 1 cycle after ready rises.
